// File: rtl/mem_access_stage.sv
// RV32I MEM stage: formats loads/stores onto a req/ready data bus, stalls while the access is in flight,
// and reports misaligned/illegal accesses combinationally and bus timeouts in DONE.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Alu_Result,
    input  logic [31:0] Store_Data,
    output logic        stall,
    output logic        mem_done,
    output logic        fault,
    output logic [31:0] MemReadData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rd_q, rd_d;
    logic        tmo_q, tmo_d;

    logic        access, illegal, misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign access  = in_valid & (MemRead | MemWrite);
    assign illegal = (MemRead & MemWrite)
                   | (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)
                   | (MemWrite & funct3[2]);
    assign misaligned = ((funct3[1:0] == 2'b01) & Alu_Result[0])
                      | ((funct3[1:0] == 2'b10) & (Alu_Result[1:0] != 2'b00));

    // Store lane formatting; loads always fetch the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = Store_Data;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << Alu_Result[1:0];
                    st_wdata = {4{Store_Data[7:0]}};
                end
                2'b01: begin
                    st_be    = Alu_Result[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{Store_Data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'b0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'b0, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        off_d    = off_q;
        rd_d     = rd_q;
        tmo_d    = tmo_q;
        stall    = 1'b0;
        mem_done = 1'b0;
        fault    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal | misaligned) begin
                        fault = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = {Alu_Result[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        f3_d    = funct3;
                        off_d   = Alu_Result[1:0];
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) rd_d = ld_fmt;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        req_d   = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = DONE;
                        if (!we_q) rd_d = '0;
                    end
                end
            end
            DONE: begin
                // The stalled instruction may still sit on the inputs; IDLE re-evaluates only the next one.
                mem_done = 1'b1;
                fault    = tmo_q;
                tmo_d    = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign MemReadData = rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage (TIMEOUT = 4): directed cases plus a short random load/store run.
module tb_mem_access_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Alu_Result, Store_Data;
    logic        stall, mem_done, fault;
    logic [31:0] MemReadData;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    typedef struct packed {
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rd = 32'h0;

    mem_access_stage #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .Alu_Result(Alu_Result), .Store_Data(Store_Data),
        .stall(stall), .mem_done(mem_done), .fault(fault), .MemReadData(MemReadData),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed access must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && mem_done) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_rdata", MemReadData, e.rd);
                check_eq("sb_fault", {31'b0, fault}, {31'b0, e.flt});
            end
        end
    end

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'b000; Alu_Result = 32'h0; Store_Data = 32'h0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    // rdy_delay < 0 means the bus never answers.
    task automatic run_access(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd, input int rdy_delay,
                              input logic [31:0] rdata, input logic [31:0] exp_rd, input logic exp_flt,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int stall_cnt = 0, req_cnt = 0, cyc = 0, done_cyc = -1;
        int exp_req, exp_stall;
        logic unstable = 1'b0;
        logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
        logic [3:0]  c_be = 4'h0;
        logic        c_we = 1'b0;
        exp_req   = (rdy_delay < 0) ? TMO : rdy_delay + 1;
        exp_stall = 1 + exp_req;
        sb_q.push_back('{rd: exp_rd, flt: exp_flt});
        @(posedge clk); #1;
        in_valid = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3; Alu_Result = addr; Store_Data = sd;
        while (done_cyc < 0 && cyc < 40) begin
            dmem_ready = dmem_req && (rdy_delay >= 0) && (req_cnt == rdy_delay);
            dmem_rdata = dmem_ready ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (dmem_req) begin
                if (req_cnt == 0) begin
                    c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata; c_we = dmem_we;
                end else if (dmem_addr !== c_addr || dmem_be !== c_be || dmem_wdata !== c_wdata || dmem_we !== c_we) begin
                    unstable = 1'b1;
                end
                req_cnt++;
            end
            if (mem_done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        check_eq({tag, "_done_cyc"}, done_cyc, exp_stall);
        check_eq({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        check_eq({tag, "_req_cycles"}, req_cnt, exp_req);
        check_eq({tag, "_addr"}, c_addr, exp_addr);
        check_eq({tag, "_be"}, {28'h0, c_be}, {28'h0, exp_be});
        check_eq({tag, "_we"}, {31'h0, c_we}, {31'h0, mw});
        if (mw) check_eq({tag, "_wdata"}, c_wdata, exp_wdata);
        check_eq({tag, "_bus_stable"}, {31'h0, unstable}, 32'h0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {31'h0, mem_done}, 32'h0);
        check_eq({tag, "_stall_after"}, {31'h0, stall}, 32'h0);
        last_rd = exp_rd;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {27'h0, stall, mem_done, fault, dmem_req, dmem_we}, 32'h0);
        check_eq({tag, "_rdata"}, MemReadData, 32'h0);
        check_eq({tag, "_addr"}, dmem_addr, 32'h0);
        check_eq({tag, "_be_wdata"}, dmem_wdata | {28'h0, dmem_be}, 32'h0);
    endtask

    task automatic bad_access(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] addr);
        @(posedge clk); #1;
        in_valid = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3; Alu_Result = addr;
        @(negedge clk);
        check_eq({tag, "_fault"}, {31'h0, fault}, 32'h1);
        check_eq({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check_eq({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
        @(negedge clk);
        check_eq({tag, "_req_next"}, {30'h0, dmem_req, stall}, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no end expected end");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0,
                   32'h100, 4'b1111, 32'h0);
        run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 3, 32'hBEEF_1234, 32'h0000_BEEF, 1'b0,
                   32'h100, 4'b1111, 32'h0);
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h006, 32'h1234_ABCD, 0, 32'h0, last_rd, 1'b0,
                   32'h004, 4'b1100, 32'hABCD_ABCD);
        bad_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101);
        bad_access("lbu_rw", 1'b1, 1'b1, 3'b100, 32'h000);
        bad_access("sbu", 1'b0, 1'b1, 3'b100, 32'h000);
        run_access("lw_tmo", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, -1, 32'h0, 32'h0, 1'b1,
                   32'h200, 4'b1111, 32'h0);

        // Reset in the second BUSY cycle, late ready one cycle after.
        @(posedge clk); #1;
        in_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b010; Alu_Result = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_all_zero("mid_busy_reset");
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        check_all_zero("late_ready");
        run_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0,
                   32'h304, 4'b1111, 32'h0);

        for (int i = 0; i < 16; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [1:0]  off;
            logic [31:0] a, sd, rw, xw;
            logic [3:0]  xb;
            logic [2:0]  ld_tab [5];
            ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            st  = 1'($urandom_range(0, 1));
            f3  = st ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
            off = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            a  = {$urandom_range(0, 32'h3FFF), off} & 32'h0000_FFFF;
            a[1:0] = off;
            sd = $urandom;
            rw = $urandom;
            xb = 4'b1111;
            xw = sd;
            if (st && f3 == 3'b000) begin xb = 4'b0001 << off; xw = {4{sd[7:0]}}; end
            if (st && f3 == 3'b001) begin xb = off[1] ? 4'b1100 : 4'b0011; xw = {2{sd[15:0]}}; end
            run_access("rnd", !st, st, f3, a, sd, int'($urandom_range(0, 2)), rw,
                       st ? last_rd : m_load(f3, off, rw), 1'b0, {a[31:2], 2'b00}, xb, xw);
        end

        repeat (3) @(posedge clk);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
